// File: rtl/fifo_drain_wr.sv
// rtl/fifo_drain_wr.sv - DMA write engine: drains the data FIFO into memory as incrementing bursts.
module fifo_drain_wr #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int LEN_WIDTH  = 16,
   parameter int DEPTH      = 256,
   parameter int BURST_LEN  = 16,
   parameter int W_DEPTH    = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  fifo_rden,
   input  logic                  fifo_rrdy,
   input  logic [DATA_WIDTH-1:0] fifo_rdata,
   input  logic [W_DEPTH-1:0]    fifo_cnt,
   output logic                  mem_awvalid,
   input  logic                  mem_awready,
   output logic [ADDR_WIDTH-1:0] mem_awaddr,
   output logic [7:0]            mem_awlen,
   output logic                  mem_wvalid,
   input  logic                  mem_wready,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  mem_wlast
);

   localparam int BYTES = DATA_WIDTH / 8;
   localparam int BW    = $clog2(BURST_LEN + 1);

   typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                state_q;
   logic [ADDR_WIDTH-1:0] cur_addr_q;
   logic [ADDR_WIDTH-1:0] awaddr_q;
   logic [LEN_WIDTH-1:0]  remaining_q;
   logic [BW-1:0]         burst_beats_q;
   logic [BW-1:0]         popped_q;
   logic [7:0]            awlen_q;
   logic                  busy_q;
   logic                  done_q;
   logic                  awvalid_q;
   logic                  wvalid_q;
   logic                  wlast_q;

   logic [BW-1:0]         beats_d;
   logic [LEN_WIDTH-1:0]  remaining_d;
   logic [ADDR_WIDTH-1:0] cur_addr_d;
   logic                  pop;
   logic                  beat_hs;

   always_comb begin
      beats_d = BW'(BURST_LEN);
      if (remaining_q < LEN_WIDTH'(BURST_LEN)) begin
         beats_d = BW'(remaining_q);
      end
   end

   assign remaining_d = remaining_q - LEN_WIDTH'(burst_beats_q);
   assign cur_addr_d  = cur_addr_q + ADDR_WIDTH'(burst_beats_q) * ADDR_WIDTH'(BYTES);
   assign beat_hs     = wvalid_q && mem_wready;

   // A pop refills the single beat register; it may overlap the beat leaving on this edge.
   always_comb begin
      pop = 1'b0;
      case (state_q)
         S_ADDR:  pop = mem_awready && fifo_rrdy && (popped_q < burst_beats_q);
         S_DATA:  pop = fifo_rrdy && (popped_q < burst_beats_q) && (!wvalid_q || mem_wready);
         default: pop = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= S_IDLE;
         cur_addr_q    <= '0;
         awaddr_q      <= '0;
         remaining_q   <= '0;
         burst_beats_q <= '0;
         popped_q      <= '0;
         awlen_q       <= '0;
         busy_q        <= 1'b0;
         done_q        <= 1'b0;
         awvalid_q     <= 1'b0;
         wvalid_q      <= 1'b0;
         wlast_q       <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  cur_addr_q  <= base_addr;
                  remaining_q <= len;
                  busy_q      <= 1'b1;
                  if (len == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (32'(fifo_cnt) >= 32'(beats_d)) begin
                  burst_beats_q <= beats_d;
                  popped_q      <= '0;
                  awaddr_q      <= cur_addr_q;
                  awlen_q       <= 8'(beats_d - BW'(1));
                  awvalid_q     <= 1'b1;
                  state_q       <= S_ADDR;
               end
            end
            S_ADDR: begin
               if (mem_awready) begin
                  awvalid_q <= 1'b0;
                  state_q   <= S_DATA;
               end
            end
            S_DATA: begin
               if (beat_hs && wlast_q) begin
                  remaining_q <= remaining_d;
                  cur_addr_q  <= cur_addr_d;
                  if (remaining_d == '0) begin
                     state_q <= S_DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= S_WAIT;
                  end
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase

         if (pop) begin
            popped_q <= popped_q + BW'(1);
            wvalid_q <= 1'b1;
            wlast_q  <= (popped_q + BW'(1) == burst_beats_q);
         end else if (beat_hs) begin
            wvalid_q <= 1'b0;
            wlast_q  <= 1'b0;
         end
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign fifo_rden   = pop;
   assign mem_awvalid = awvalid_q;
   assign mem_awaddr  = awaddr_q;
   assign mem_awlen   = awlen_q;
   assign mem_wvalid  = wvalid_q;
   assign mem_wlast   = wlast_q;
   assign mem_wdata   = wvalid_q ? fifo_rdata : '0;

endmodule

// File: tb/tb_fifo_drain_wr.sv
// tb/tb_fifo_drain_wr.sv - bench for fifo_drain_wr with a FIFO model and burst scoreboard.
module tb_fifo_drain_wr;

   localparam int DW = 32, AW = 32, LW = 16, DEPTH = 256, BL = 16;
   localparam int WD = $clog2(DEPTH);

   logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
   logic [AW-1:0] base_addr = '0;
   logic [LW-1:0] len = '0;
   logic          busy, done, fifo_rden;
   logic          fifo_rrdy = 1'b0;
   logic [DW-1:0] fifo_rdata = '0;
   logic [WD-1:0] fifo_cnt = '0;
   logic          mem_awvalid, mem_awready = 1'b1;
   logic [AW-1:0] mem_awaddr;
   logic [7:0]    mem_awlen;
   logic          mem_wvalid, mem_wready = 1'b1;
   logic [DW-1:0] mem_wdata;
   logic          mem_wlast;

   fifo_drain_wr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW), .DEPTH(DEPTH), .BURST_LEN(BL)) dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
      .busy(busy), .done(done), .fifo_rden(fifo_rden), .fifo_rrdy(fifo_rrdy),
      .fifo_rdata(fifo_rdata), .fifo_cnt(fifo_cnt), .mem_awvalid(mem_awvalid),
      .mem_awready(mem_awready), .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_wdata(mem_wdata),
      .mem_wlast(mem_wlast)
   );

   always #5 clk = ~clk;

   int vectors = 0, miscompares = 0;
   int cyc = 0, pops = 0, done_cnt = 0, busy_cycles = 0, stab_err = 0, empty_pops = 0;
   logic [DW-1:0] exp_data[$], obs_data[$];
   logic          exp_last[$], obs_last[$];
   logic [AW-1:0] exp_aw_addr[$], obs_aw_addr[$];
   logic [7:0]    exp_aw_len[$], obs_aw_len[$];
   int            obs_aw_cnt[$], obs_cyc[$];
   logic [DW-1:0] next_word = 32'hA000_0000;
   logic          push_req = 1'b0;
   logic [DW-1:0] push_data = '0;

   // FIFO model: registered read data, occupancy updated after pop/push each edge
   logic [DW-1:0] fq[$];
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fq.delete();
         fifo_rrdy  <= 1'b0;
         fifo_cnt   <= '0;
         fifo_rdata <= '0;
      end else begin
         if (fifo_rden) begin
            if (fq.size() == 0) empty_pops++;
            else fifo_rdata <= fq.pop_front();
         end
         if (push_req) fq.push_back(push_data);
         fifo_rrdy <= (fq.size() != 0);
         fifo_cnt  <= WD'(fq.size());
      end
   end

   // Monitor: records handshakes and tracks stability of stalled valids
   logic          w_pend = 1'b0, aw_pend = 1'b0, pend_l = 1'b0;
   logic [DW-1:0] pend_d = '0;
   logic [AW-1:0] pend_a = '0;
   logic [7:0]    pend_len = '0;
   int            cnt_prev = 0;
   always @(negedge clk) begin
      cyc++;
      if (rst) begin
         w_pend  = 1'b0;
         aw_pend = 1'b0;
      end else begin
         if (w_pend && (!mem_wvalid || mem_wdata !== pend_d || mem_wlast !== pend_l)) stab_err++;
         if (aw_pend && (!mem_awvalid || mem_awaddr !== pend_a || mem_awlen !== pend_len)) stab_err++;
         if (mem_awvalid && !aw_pend) begin
            obs_aw_addr.push_back(mem_awaddr);
            obs_aw_len.push_back(mem_awlen);
            obs_aw_cnt.push_back(cnt_prev);
         end
         aw_pend  = mem_awvalid && !mem_awready;
         pend_a   = mem_awaddr;
         pend_len = mem_awlen;
         if (mem_wvalid && mem_wready) begin
            obs_data.push_back(mem_wdata);
            obs_last.push_back(mem_wlast);
            obs_cyc.push_back(cyc);
         end
         w_pend = mem_wvalid && !mem_wready;
         pend_d = mem_wdata;
         pend_l = mem_wlast;
         if (fifo_rden) pops++;
         if (busy) busy_cycles++;
         if (done) done_cnt++;
      end
      cnt_prev = int'(fifo_cnt);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic feed_cycle(input logic p);
      push_req = p;
      if (p) begin
         push_data = next_word;
         exp_data.push_back(next_word);
         next_word = next_word + 32'h11;
      end
      tick();
      push_req = 1'b0;
   endtask

   task automatic pulse_start(input logic [AW-1:0] a, input int n);
      base_addr = a;
      len       = LW'(n);
      start     = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic expect_xfer(input logic [AW-1:0] a, input int n);
      int rem;
      logic [AW-1:0] ad;
      rem = n;
      ad  = a;
      while (rem > 0) begin
         int b;
         b = (rem < BL) ? rem : BL;
         exp_aw_addr.push_back(ad);
         exp_aw_len.push_back(8'(b - 1));
         for (int i = 0; i < b; i++) exp_last.push_back(i == b - 1);
         ad  = ad + AW'(b * (DW / 8));
         rem = rem - b;
      end
   endtask

   task automatic clear_q;
      exp_data.delete(); obs_data.delete(); exp_last.delete(); obs_last.delete();
      exp_aw_addr.delete(); obs_aw_addr.delete(); exp_aw_len.delete(); obs_aw_len.delete();
      obs_aw_cnt.delete(); obs_cyc.delete();
   endtask

   task automatic test_reset;
      repeat (3) tick();
      vectors++;
      if ({busy, done, fifo_rden, mem_awvalid, mem_wvalid, mem_wlast} !== 6'b0) begin
         miscompares++;
         $display("FAIL reset_ctrl got %b want 000000", {busy, done, fifo_rden, mem_awvalid, mem_wvalid, mem_wlast});
      end
      rst = 1'b0;
      repeat (2) tick();
      vectors++;
      if ({mem_awaddr, mem_awlen, mem_wdata, busy, done} !== '0) begin
         miscompares++;
         $display("FAIL reset_data got awaddr=%h awlen=%h wdata=%h busy=%b done=%b want all 0", mem_awaddr, mem_awlen, mem_wdata, busy, done);
      end
   endtask

   task automatic test_len_zero;
      int d0, b0, p0;
      d0 = done_cnt; b0 = busy_cycles; p0 = pops;
      pulse_start(32'h0000_1000, 0);
      vectors++;
      if ({done, busy} !== 2'b11) begin
         miscompares++;
         $display("FAIL len0_pulse got done=%b busy=%b want done=1 busy=1", done, busy);
      end
      repeat (4) tick();
      vectors++;
      if (done_cnt - d0 != 1 || busy_cycles - b0 != 1 || pops != p0 || obs_aw_addr.size() != 0) begin
         miscompares++;
         $display("FAIL len0_totals got done=%0d busy_cyc=%0d pops=%0d aw=%0d want 1 1 0 0", done_cnt - d0, busy_cycles - b0, pops - p0, obs_aw_addr.size());
      end
   endtask

   task automatic test_single_burst;
      int d0;
      logic [DW-1:0] d, e;
      logic l, el;
      clear_q();
      for (int i = 0; i < 16; i++) feed_cycle(1'b1);
      d0 = done_cnt;
      pulse_start(32'h0000_1000, 16);
      expect_xfer(32'h0000_1000, 16);
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      vectors++;
      if (done_cnt != d0 + 1) begin
         miscompares++;
         $display("FAIL single_done got %0d pulses want 1", done_cnt - d0);
      end
      vectors++;
      if (obs_cyc.size() != 16 || obs_cyc[obs_cyc.size() - 1] - obs_cyc[0] != 15) begin
         miscompares++;
         $display("FAIL single_rate got %0d beats want 16 in 16 consecutive cycles", obs_cyc.size());
      end
      vectors++;
      if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 32'h1000 || obs_aw_len[0] !== 8'd15) begin
         miscompares++;
         $display("FAIL single_aw got count=%0d want one burst addr=00001000 len=15", obs_aw_addr.size());
      end
      while (exp_data.size() > 0 && obs_data.size() > 0) begin
         d = obs_data.pop_front(); e = exp_data.pop_front();
         l = obs_last.pop_front(); el = exp_last.pop_front();
         vectors++;
         if (d !== e || l !== el) begin
            miscompares++;
            $display("FAIL single_beat got data=%h last=%b want data=%h last=%b", d, l, e, el);
         end
      end
      vectors++;
      if (exp_data.size() != 0 || obs_data.size() != 0) begin
         miscompares++;
         $display("FAIL single_beat_count got leftover obs=%0d exp=%0d want 0 0", obs_data.size(), exp_data.size());
      end
   endtask

   task automatic test_slow_feed;
      int d0, fed, e0;
      logic [AW-1:0] a, ea;
      logic [7:0] l, el;
      int c;
      clear_q();
      d0 = done_cnt; fed = 0; e0 = empty_pops;
      pulse_start(32'h0000_1000, 40);
      expect_xfer(32'h0000_1000, 40);
      for (int i = 0; i < 2000 && done_cnt == d0; i++) begin
         if (i % 4 == 0 && fed < 40) begin
            feed_cycle(1'b1);
            fed++;
         end else begin
            feed_cycle(1'b0);
         end
      end
      vectors++;
      if (done_cnt != d0 + 1 || empty_pops != e0) begin
         miscompares++;
         $display("FAIL slow_done got done=%0d empty_pops=%0d want 1 0", done_cnt - d0, empty_pops - e0);
      end
      vectors++;
      if (obs_aw_addr.size() != exp_aw_addr.size()) begin
         miscompares++;
         $display("FAIL slow_aw_count got %0d want %0d", obs_aw_addr.size(), exp_aw_addr.size());
      end
      while (exp_aw_addr.size() > 0 && obs_aw_addr.size() > 0) begin
         a = obs_aw_addr.pop_front(); ea = exp_aw_addr.pop_front();
         l = obs_aw_len.pop_front(); el = exp_aw_len.pop_front();
         c = obs_aw_cnt.pop_front();
         vectors++;
         if (a !== ea || l !== el || c != int'(el) + 1) begin
            miscompares++;
            $display("FAIL slow_aw got addr=%h len=%0d cnt=%0d want addr=%h len=%0d cnt=%0d", a, l, c, ea, el, int'(el) + 1);
         end
      end
      vectors++;
      if (obs_data != exp_data || obs_last != exp_last) begin
         miscompares++;
         $display("FAIL slow_data got %0d beats want %0d beats in order with wlast at 16/32/40", obs_data.size(), exp_data.size());
      end
   endtask

   task automatic test_wready_stall;
      int d0, p0, s0;
      logic [DW-1:0] d, e;
      logic l, el;
      clear_q();
      for (int i = 0; i < 16; i++) feed_cycle(1'b1);
      d0 = done_cnt; p0 = pops; s0 = stab_err;
      pulse_start(32'h0000_2000, 16);
      expect_xfer(32'h0000_2000, 16);
      for (int i = 0; i < 600 && done_cnt == d0; i++) begin
         mem_wready  = 1'($urandom_range(0, 1));
         mem_awready = 1'($urandom_range(0, 1));
         feed_cycle(1'b0);
      end
      mem_wready = 1'b1; mem_awready = 1'b1;
      vectors++;
      if (done_cnt != d0 + 1 || pops - p0 != 16 || stab_err != s0) begin
         miscompares++;
         $display("FAIL stall_totals got done=%0d pops=%0d unstable=%0d want 1 16 0", done_cnt - d0, pops - p0, stab_err - s0);
      end
      vectors++;
      if (obs_aw_len.size() != 1 || obs_aw_addr[0] !== 32'h2000 || obs_aw_len[0] !== 8'd15) begin
         miscompares++;
         $display("FAIL stall_aw got count=%0d want one burst addr=00002000 len=15", obs_aw_len.size());
      end
      while (exp_data.size() > 0 && obs_data.size() > 0) begin
         d = obs_data.pop_front(); e = exp_data.pop_front();
         l = obs_last.pop_front(); el = exp_last.pop_front();
         vectors++;
         if (d !== e || l !== el) begin
            miscompares++;
            $display("FAIL stall_beat got data=%h last=%b want data=%h last=%b", d, l, e, el);
         end
      end
   endtask

   task automatic test_reset_mid;
      int d0;
      clear_q();
      for (int i = 0; i < 16; i++) feed_cycle(1'b1);
      d0 = done_cnt;
      pulse_start(32'h0000_3000, 16);
      for (int i = 0; i < 100 && obs_data.size() < 4; i++) tick();
      vectors++;
      if (obs_data.size() != 4 || !mem_wvalid) begin
         miscompares++;
         $display("FAIL rstmid_reach got beats=%0d wvalid=%b want 4 beats done and beat 5 pending", obs_data.size(), mem_wvalid);
      end
      #2 rst = 1'b1;
      #1;
      vectors++;
      if ({busy, done, fifo_rden, mem_awvalid, mem_wvalid, mem_wlast, mem_awaddr, mem_awlen, mem_wdata} !== '0) begin
         miscompares++;
         $display("FAIL rstmid_outputs got busy=%b done=%b rden=%b awv=%b wv=%b wl=%b awaddr=%h awlen=%h wdata=%h want all 0",
                  busy, done, fifo_rden, mem_awvalid, mem_wvalid, mem_wlast, mem_awaddr, mem_awlen, mem_wdata);
      end
      repeat (2) tick();
      rst = 1'b0;
      repeat (3) tick();
      vectors++;
      if (done_cnt != d0) begin
         miscompares++;
         $display("FAIL rstmid_nodone got %0d pulses want 0", done_cnt - d0);
      end
      clear_q();
      for (int i = 0; i < 4; i++) feed_cycle(1'b1);
      pulse_start(32'h0000_4000, 4);
      expect_xfer(32'h0000_4000, 4);
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      vectors++;
      if (done_cnt != d0 + 1 || obs_data != exp_data || obs_last != exp_last) begin
         miscompares++;
         $display("FAIL rstmid_restart got done=%0d beats=%0d want done=1 beats=%0d matching", done_cnt - d0, obs_data.size(), exp_data.size());
      end
      vectors++;
      if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 32'h4000 || obs_aw_len[0] !== 8'd3) begin
         miscompares++;
         $display("FAIL rstmid_aw got count=%0d want one burst addr=00004000 len=3", obs_aw_addr.size());
      end
   endtask

   task automatic test_start_busy;
      int d0;
      clear_q();
      d0 = done_cnt;
      pulse_start(32'h0000_5000, 8);
      expect_xfer(32'h0000_5000, 8);
      tick();
      pulse_start(32'h0000_9000, 3);
      base_addr = 32'hDEAD_0000;
      len       = 16'd99;
      for (int i = 0; i < 8; i++) feed_cycle(1'b1);
      for (int i = 0; i < 200 && done_cnt == d0; i++) tick();
      repeat (20) tick();
      vectors++;
      if (done_cnt != d0 + 1) begin
         miscompares++;
         $display("FAIL busy_done got %0d pulses want 1", done_cnt - d0);
      end
      vectors++;
      if (obs_aw_addr.size() != 1 || obs_aw_addr[0] !== 32'h5000 || obs_aw_len[0] !== 8'd7 || obs_aw_cnt[0] != 8) begin
         miscompares++;
         $display("FAIL busy_aw got count=%0d want one burst addr=00005000 len=7 cnt=8", obs_aw_addr.size());
      end
      vectors++;
      if (obs_data != exp_data || obs_last != exp_last) begin
         miscompares++;
         $display("FAIL busy_data got %0d beats want %0d in order", obs_data.size(), exp_data.size());
      end
   endtask

   initial begin
      test_reset();
      test_len_zero();
      test_single_burst();
      test_slow_feed();
      test_wready_stall();
      test_reset_mid();
      test_start_busy();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/fifo_drain_wr.md
Name: fifo_drain_wr

Overview:
- DMA write-side engine that drains the block-RAM-backed data FIFO and writes its contents to memory as incrementing bursts.
- Sits on the FIFO read port (rden/rrdy/rdata/cnt) and drives a simplified AXI-style write-address/write-data channel pair.
- Software programs a base address and a word count, then pulses start; the block reports busy and pulses done on completion.

Parameters:
- DATA_WIDTH, 32, FIFO word and memory data width; must be a power of two, >= 8.
- ADDR_WIDTH, 32, memory byte-address width.
- LEN_WIDTH, 16, width of the transfer length in words.
- DEPTH, 256, depth of the attached FIFO; W_DEPTH = clog2(DEPTH) is the width of fifo_cnt.
- BURST_LEN, 16, maximum beats per burst; 1 <= BURST_LEN < DEPTH.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset.
- start  in  1  one-cycle pulse; sampled only in IDLE.
- base_addr  in  ADDR_WIDTH  first byte address; captured on accepted start.
- len  in  LEN_WIDTH  words to transfer; captured on accepted start.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- fifo_rden  out  1  FIFO pop.
- fifo_rrdy  in  1  FIFO non-empty.
- fifo_rdata  in  DATA_WIDTH  FIFO read data; valid the cycle after fifo_rden and held until the next pop.
- fifo_cnt  in  W_DEPTH  FIFO occupancy.
- mem_awvalid / mem_awready  out / in  1  address handshake.
- mem_awaddr  out  ADDR_WIDTH  burst start byte address.
- mem_awlen  out  8  beats minus 1.
- mem_wvalid / mem_wready  out / in  1  data handshake.
- mem_wdata  out  DATA_WIDTH  driven combinationally from fifo_rdata.
- mem_wlast  out  1  marks the final beat of a burst.

Behaviour:
- One clock; reset is asynchronous and active-high.
- On reset, every output is 0, the FSM goes to IDLE, and all internal counters clear. Reset mid-transfer abandons the transfer with no done pulse.
- The handshake follows AXI rules: a transfer occurs when valid && ready on a rising edge. Once asserted, valid stays high and awaddr/awlen/wdata/wlast stay stable until the handshake.
- BYTES = DATA_WIDTH/8. beats = min(remaining, BURST_LEN), computed in WAIT.
- FSM states:
  - IDLE: on start, latch cur_addr = base_addr and remaining = len. If len == 0, go to DONE; otherwise go to WAIT. start in any other state is ignored.
  - WAIT: stay while fifo_cnt < beats. When fifo_cnt >= beats, latch burst_beats = beats and go to ADDR.
  - ADDR: mem_awvalid = 1, mem_awaddr = cur_addr, mem_awlen = burst_beats - 1. On awready, go to DATA. The first fifo_rden may be issued in the same cycle as the awready handshake.
  - DATA: fifo_rden is asserted when all of the following hold:
    - popped < burst_beats;
    - fifo_rrdy;
    - no beat is pending, or the pending beat handshakes this cycle.
  - DATA, beat timing: a beat becomes pending (mem_wvalid = 1) the cycle after fifo_rden. mem_wlast = 1 when the pending beat is number burst_beats.
  - DATA, throughput: 1 beat/cycle when wready is held high.
  - DATA, burst end: on the wlast handshake, remaining -= burst_beats and cur_addr += burst_beats*BYTES (wraps modulo 2^ADDR_WIDTH). If remaining == 0, go to DONE; otherwise go to WAIT.
  - DONE: done = 1 for exactly one cycle, then IDLE. busy is still 1 in DONE.
- Never pops more than burst_beats per burst and never pops while the FIFO is empty. fifo_rden is 0 outside ADDR and DATA.
- A wready stall holds the pending beat; no further pop occurs until it is accepted.
- The final burst is short when remaining < BURST_LEN; awlen reflects the short length.
- A FIFO write concurrent with a pop needs no special handling; gating uses only fifo_cnt in WAIT.

Test Plan:
- len=0, start -> no awvalid/rden, done pulses the cycle after start, busy high for exactly 1 cycle.
- base_addr=0x1000, len=16, BURST_LEN=16, FIFO preloaded 0..15, awready/wready tied 1 -> one burst: awaddr=0x1000, awlen=15; 16 beats in 16 consecutive cycles, data 0..15, wlast on beat 16, done follows.
- len=40, BURST_LEN=16, FIFO fed 1 word/4 cycles -> bursts at 0x1000/0x1040/0x1080 with awlen 15/15/7; each awvalid appears only once fifo_cnt reaches 16/16/8; never pops empty.
- wready random 50% during a 16-beat burst -> wdata/wlast stable while stalled; exactly 16 pops; order preserved.
- rst asserted at beat 5 of a burst -> all outputs 0 immediately (asynchronous), no done; next start with len=4 completes normally.
- start pulsed while busy -> ignored; base_addr/len changes have no effect on the transfer in flight.
